json_tokenizer: RTL and testbench



---
 rtl/json_tokenizer.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_json_tokenizer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/json_tokenizer.sv
// JSON lexer: consumes one ASCII byte per handshake and emits tokens through a
// single registered output slot; lexical errors latch a sticky error state.
module json_tokenizer #(
    parameter int unsigned NUM_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [3:0]       tok_type,
    output logic [NUM_W-1:0] tok_value,
    output logic             tok_last,
    output logic             err
);

    localparam int unsigned    AW      = NUM_W + 4;
    localparam logic [AW-1:0]  LIM_NEG = AW'(1) << (NUM_W - 1);
    localparam logic [AW-1:0]  LIM_POS = LIM_NEG - AW'(1);

    localparam logic [3:0] T_LBRACE    = 4'd0;
    localparam logic [3:0] T_RBRACE    = 4'd1;
    localparam logic [3:0] T_LBRACK    = 4'd2;
    localparam logic [3:0] T_RBRACK    = 4'd3;
    localparam logic [3:0] T_COLON     = 4'd4;
    localparam logic [3:0] T_COMMA     = 4'd5;
    localparam logic [3:0] T_TRUE      = 4'd6;
    localparam logic [3:0] T_FALSE     = 4'd7;
    localparam logic [3:0] T_NULL      = 4'd8;
    localparam logic [3:0] T_NUMBER    = 4'd9;
    localparam logic [3:0] T_STR_BEGIN = 4'd10;
    localparam logic [3:0] T_STR_CHAR  = 4'd11;
    localparam logic [3:0] T_STR_END   = 4'd12;
    localparam logic [3:0] T_ERROR     = 4'd15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STRING  = 3'd1,
        ESCAPE  = 3'd2,
        NUMBER  = 3'd3,
        LITERAL = 3'd4,
        FAIL    = 3'd5
    } state_t;

    state_t           state, state_d;
    logic [NUM_W-1:0] acc, acc_d;
    logic             neg, neg_d;
    logic             has_dig, has_dig_d;
    logic [1:0]       lit_sel, lit_sel_d;
    logic [2:0]       lit_cnt, lit_cnt_d;
    logic             err_d;

    logic             emit;
    logic [3:0]       emit_type;
    logic [NUM_W-1:0] emit_value;
    logic             emit_last;
    logic             go_fail;

    logic             slot_free;
    logic             is_digit;
    logic             is_ws;
    logic             hold;
    logic             fire;
    logic [AW-1:0]    acc_wide;
    logic [NUM_W-1:0] acc_grow;
    logic [7:0]       esc_char;
    logic             esc_ok;
    logic [2:0]       lit_end;
    logic [3:0]       lit_type;

    // Character expected at position idx of "true" / "false" / "null".
    function automatic logic [7:0] lit_char(input logic [1:0] sel, input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h00;
        case ({sel, idx})
            5'b00_001: c = "r";
            5'b00_010: c = "u";
            5'b00_011: c = "e";
            5'b01_001: c = "a";
            5'b01_010: c = "l";
            5'b01_011: c = "s";
            5'b01_100: c = "e";
            5'b10_001: c = "u";
            5'b10_010: c = "l";
            5'b10_011: c = "l";
            default:   c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [NUM_W-1:0] signed_value(input logic [NUM_W-1:0] mag,
                                                      input logic is_neg);
        return is_neg ? (~mag + NUM_W'(1)) : mag;
    endfunction

    assign slot_free = !tok_valid || tok_ready;
    assign is_digit  = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_ws     = (in_data == 8'h20) || (in_data == 8'h09) ||
                       (in_data == 8'h0D) || (in_data == 8'h0A);
    // A number ends on the first non-digit, which is left unconsumed for IDLE.
    assign hold      = (state == NUMBER) && in_valid && !is_digit;
    assign in_ready  = rst_n && ((state == FAIL) || (slot_free && !hold));
    assign fire      = in_valid && in_ready;
    assign acc_wide  = AW'(acc) * AW'(10) + AW'(in_data[3:0]);
    assign acc_grow  = acc_wide[NUM_W-1:0];
    assign lit_end   = (lit_sel == 2'd1) ? 3'd4 : 3'd3;

    always_comb begin
        esc_ok   = 1'b1;
        esc_char = 8'h00;
        case (in_data)
            8'h22:   esc_char = 8'h22;
            8'h5C:   esc_char = 8'h5C;
            "/":     esc_char = 8'h2F;
            "b":     esc_char = 8'h08;
            "f":     esc_char = 8'h0C;
            "n":     esc_char = 8'h0A;
            "r":     esc_char = 8'h0D;
            "t":     esc_char = 8'h09;
            default: esc_ok   = 1'b0;
        endcase
    end

    always_comb begin
        case (lit_sel)
            2'd0:    lit_type = T_TRUE;
            2'd1:    lit_type = T_FALSE;
            default: lit_type = T_NULL;
        endcase
    end

    always_comb begin
        state_d    = state;
        acc_d      = acc;
        neg_d      = neg;
        has_dig_d  = has_dig;
        lit_sel_d  = lit_sel;
        lit_cnt_d  = lit_cnt;
        err_d      = err;
        emit       = 1'b0;
        emit_type  = T_LBRACE;
        emit_value = '0;
        emit_last  = in_last;
        go_fail    = 1'b0;

        case (state)
            IDLE: begin
                if (fire) begin
                    if (is_digit) begin
                        neg_d = 1'b0;
                        if (in_last) begin
                            emit       = 1'b1;
                            emit_type  = T_NUMBER;
                            emit_value = NUM_W'(in_data[3:0]);
                        end else begin
                            acc_d     = NUM_W'(in_data[3:0]);
                            has_dig_d = 1'b1;
                            state_d   = NUMBER;
                        end
                    end else if (!is_ws) begin
                        emit = 1'b1;
                        case (in_data)
                            "{": emit_type = T_LBRACE;
                            "}": emit_type = T_RBRACE;
                            "[": emit_type = T_LBRACK;
                            "]": emit_type = T_RBRACK;
                            ":": emit_type = T_COLON;
                            ",": emit_type = T_COMMA;
                            8'h22: begin
                                emit_type = T_STR_BEGIN;
                                state_d   = STRING;
                                go_fail   = in_last;
                            end
                            "-": begin
                                emit      = 1'b0;
                                acc_d     = '0;
                                neg_d     = 1'b1;
                                has_dig_d = 1'b0;
                                state_d   = NUMBER;
                                go_fail   = in_last;
                            end
                            "t", "f", "n": begin
                                emit      = 1'b0;
                                lit_sel_d = (in_data == "t") ? 2'd0 :
                                            (in_data == "f") ? 2'd1 : 2'd2;
                                lit_cnt_d = 3'd1;
                                state_d   = LITERAL;
                                go_fail   = in_last;
                            end
                            default: go_fail = 1'b1;
                        endcase
                    end
                end
            end
            NUMBER: begin
                if (hold) begin
                    if (slot_free) begin
                        if (!has_dig) begin
                            go_fail = 1'b1;
                        end else begin
                            emit       = 1'b1;
                            emit_type  = T_NUMBER;
                            emit_value = signed_value(acc, neg);
                            emit_last  = 1'b0;
                            state_d    = IDLE;
                        end
                    end
                end else if (fire) begin
                    if (acc_wide > (neg ? LIM_NEG : LIM_POS)) begin
                        go_fail = 1'b1;
                    end else if (in_last) begin
                        emit       = 1'b1;
                        emit_type  = T_NUMBER;
                        emit_value = signed_value(acc_grow, neg);
                        state_d    = IDLE;
                    end else begin
                        acc_d     = acc_grow;
                        has_dig_d = 1'b1;
                    end
                end
            end
            STRING: begin
                if (fire) begin
                    if (in_data == 8'h22) begin
                        emit      = 1'b1;
                        emit_type = T_STR_END;
                        state_d   = IDLE;
                    end else if (in_last || (in_data < 8'h20)) begin
                        go_fail = 1'b1;
                    end else if (in_data == 8'h5C) begin
                        state_d = ESCAPE;
                    end else begin
                        emit       = 1'b1;
                        emit_type  = T_STR_CHAR;
                        emit_value = NUM_W'(in_data);
                    end
                end
            end
            ESCAPE: begin
                if (fire) begin
                    if (esc_ok && !in_last) begin
                        emit       = 1'b1;
                        emit_type  = T_STR_CHAR;
                        emit_value = NUM_W'(esc_char);
                        state_d    = STRING;
                    end else begin
                        go_fail = 1'b1;
                    end
                end
            end
            LITERAL: begin
                if (fire) begin
                    if (in_data != lit_char(lit_sel, lit_cnt)) begin
                        go_fail = 1'b1;
                    end else if (lit_cnt == lit_end) begin
                        emit      = 1'b1;
                        emit_type = lit_type;
                        state_d   = IDLE;
                    end else if (in_last) begin
                        go_fail = 1'b1;
                    end else begin
                        lit_cnt_d = lit_cnt + 3'd1;
                    end
                end
            end
            default: begin
            end
        endcase

        if (go_fail) begin
            state_d    = FAIL;
            emit       = 1'b1;
            emit_type  = T_ERROR;
            emit_value = '0;
            emit_last  = 1'b1;
            err_d      = 1'b1;
        end

        // Every return to IDLE starts the next token from a clean slate.
        if (state_d == IDLE || state_d == FAIL) begin
            acc_d     = '0;
            neg_d     = 1'b0;
            has_dig_d = 1'b0;
            lit_sel_d = '0;
            lit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            neg       <= 1'b0;
            has_dig   <= 1'b0;
            lit_sel   <= '0;
            lit_cnt   <= '0;
            err       <= 1'b0;
            tok_valid <= 1'b0;
            tok_type  <= '0;
            tok_value <= '0;
            tok_last  <= 1'b0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            neg     <= neg_d;
            has_dig <= has_dig_d;
            lit_sel <= lit_sel_d;
            lit_cnt <= lit_cnt_d;
            err     <= err_d;
            if (emit) begin
                tok_valid <= 1'b1;
                tok_type  <= emit_type;
                tok_value <= emit_value;
                tok_last  <= emit_last;
            end else if (tok_ready) begin
                tok_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_json_tokenizer.sv
// Directed self-checking bench for json_tokenizer: drives JSON byte streams
// and compares the accepted token sequence against hand-derived expectations.
module tb_json_tokenizer;

    localparam int unsigned NUM_W = 32;

    localparam logic [3:0] T_LBRACE    = 4'd0;
    localparam logic [3:0] T_RBRACE    = 4'd1;
    localparam logic [3:0] T_LBRACK    = 4'd2;
    localparam logic [3:0] T_RBRACK    = 4'd3;
    localparam logic [3:0] T_COLON     = 4'd4;
    localparam logic [3:0] T_COMMA     = 4'd5;
    localparam logic [3:0] T_TRUE      = 4'd6;
    localparam logic [3:0] T_FALSE     = 4'd7;
    localparam logic [3:0] T_NULL      = 4'd8;
    localparam logic [3:0] T_NUMBER    = 4'd9;
    localparam logic [3:0] T_STR_BEGIN = 4'd10;
    localparam logic [3:0] T_STR_CHAR  = 4'd11;
    localparam logic [3:0] T_STR_END   = 4'd12;
    localparam logic [3:0] T_ERROR     = 4'd15;

    typedef struct packed {
        logic [3:0]       typ;
        logic [NUM_W-1:0] val;
        logic             last;
    } tok_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             tok_valid;
    logic             tok_ready = 1'b1;
    logic [3:0]       tok_type;
    logic [NUM_W-1:0] tok_value;
    logic             tok_last;
    logic             err;

    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;
    tok_t got[$];
    tok_t exp[$];

    json_tokenizer #(.NUM_W(NUM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_type  (tok_type),
        .tok_value (tok_value),
        .tok_last  (tok_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Record every token that will complete its handshake on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && tok_valid && tok_ready)
            got.push_back({tok_type, tok_value, tok_last});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic tok_t mk(input logic [3:0] t, input logic [NUM_W-1:0] v, input logic l);
        tok_t r;
        r.typ  = t;
        r.val  = v;
        r.last = l;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        stalls += n;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h in_ready=%b, required 1 within 100 cycles", b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++)
            send(s[i], last && (i == s.len() - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        checks++;
        if (tok_valid !== 1'b0) begin errors++; $display("FAIL reset_tok_valid: got %b, required 0", tok_valid); end
        checks++;
        if (tok_type !== 4'd0) begin errors++; $display("FAIL reset_tok_type: got %0d, required 0", tok_type); end
        checks++;
        if (tok_value !== '0) begin errors++; $display("FAIL reset_tok_value: got %h, required 0", tok_value); end
        checks++;
        if (tok_last !== 1'b0) begin errors++; $display("FAIL reset_tok_last: got %b, required 0", tok_last); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        got.delete();
        exp.delete();
        stalls = 0;
        send_str("{}[]:,42", 1'b1);
        idle(3);
        exp.push_back(mk(T_LBRACE, 0, 0));
        exp.push_back(mk(T_RBRACE, 0, 0));
        exp.push_back(mk(T_LBRACK, 0, 0));
        exp.push_back(mk(T_RBRACK, 0, 0));
        exp.push_back(mk(T_COLON, 0, 0));
        exp.push_back(mk(T_COMMA, 0, 0));
        exp.push_back(mk(T_NUMBER, 32'd42, 1));
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL b2b_stalls: got %0d, required 0", stalls); end
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL b2b_count: got %0d tokens, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++;
                $display("FAIL b2b_tok%0d: missing, required type %0d value %h last %b", i, exp[i].typ, exp[i].val, exp[i].last);
            end else if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_tok%0d: type %0d value %h last %b, required type %0d value %h last %b",
                         i, got[i].typ, got[i].val, got[i].last, exp[i].typ, exp[i].val, exp[i].last);
            end
        end
    endtask

    task automatic test_object;
        got.delete();
        exp.delete();
        send_str("{\"a\":[12,-7]}", 1'b1);
        idle(3);
        exp.push_back(mk(T_LBRACE, 0, 0));
        exp.push_back(mk(T_STR_BEGIN, 0, 0));
        exp.push_back(mk(T_STR_CHAR, 32'h61, 0));
        exp.push_back(mk(T_STR_END, 0, 0));
        exp.push_back(mk(T_COLON, 0, 0));
        exp.push_back(mk(T_LBRACK, 0, 0));
        exp.push_back(mk(T_NUMBER, 32'd12, 0));
        exp.push_back(mk(T_COMMA, 0, 0));
        exp.push_back(mk(T_NUMBER, 32'hFFFF_FFF9, 0));
        exp.push_back(mk(T_RBRACK, 0, 0));
        exp.push_back(mk(T_RBRACE, 0, 1));
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL obj_count: got %0d tokens, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++;
                $display("FAIL obj_tok%0d: missing, required type %0d value %h last %b", i, exp[i].typ, exp[i].val, exp[i].last);
            end else if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL obj_tok%0d: type %0d value %h last %b, required type %0d value %h last %b",
                         i, got[i].typ, got[i].val, got[i].last, exp[i].typ, exp[i].val, exp[i].last);
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL obj_err: got %b, required 0", err); end
    endtask

    task automatic test_strings_literals;
        got.delete();
        exp.delete();
        send_str("\"x\\n\\\"\" true null false", 1'b1);
        idle(3);
        exp.push_back(mk(T_STR_BEGIN, 0, 0));
        exp.push_back(mk(T_STR_CHAR, 32'h78, 0));
        exp.push_back(mk(T_STR_CHAR, 32'h0A, 0));
        exp.push_back(mk(T_STR_CHAR, 32'h22, 0));
        exp.push_back(mk(T_STR_END, 0, 0));
        exp.push_back(mk(T_TRUE, 0, 0));
        exp.push_back(mk(T_NULL, 0, 0));
        exp.push_back(mk(T_FALSE, 0, 1));
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL strlit_count: got %0d tokens, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++;
                $display("FAIL strlit_tok%0d: missing, required type %0d value %h last %b", i, exp[i].typ, exp[i].val, exp[i].last);
            end else if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL strlit_tok%0d: type %0d value %h last %b, required type %0d value %h last %b",
                         i, got[i].typ, got[i].val, got[i].last, exp[i].typ, exp[i].val, exp[i].last);
            end
        end
    endtask

    task automatic test_number_bounds;
        got.delete();
        exp.delete();
        send_str("2147483647 -2147483648 2147483648", 1'b0);
        idle(2);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL bounds_err: got %b, required 1", err); end
        stalls = 0;
        send_str(" 5]", 1'b1);
        idle(3);
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL bounds_discard_stalls: got %0d, required 0", stalls); end
        checks++;
        if (tok_valid !== 1'b0) begin errors++; $display("FAIL bounds_quiet: tok_valid %b, required 0", tok_valid); end
        exp.push_back(mk(T_NUMBER, 32'h7FFF_FFFF, 0));
        exp.push_back(mk(T_NUMBER, 32'h8000_0000, 0));
        exp.push_back(mk(T_ERROR, 0, 1));
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL bounds_count: got %0d tokens, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++;
                $display("FAIL bounds_tok%0d: missing, required type %0d value %h last %b", i, exp[i].typ, exp[i].val, exp[i].last);
            end else if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL bounds_tok%0d: type %0d value %h last %b, required type %0d value %h last %b",
                         i, got[i].typ, got[i].val, got[i].last, exp[i].typ, exp[i].val, exp[i].last);
            end
        end
        do_reset(1);
    endtask

    task automatic test_backpressure;
        got.delete();
        exp.delete();
        tok_ready = 1'b0;
        send("7", 1'b0);
        in_valid = 1'b1;
        in_data  = ",";
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tok_valid !== 1'b1 || tok_type !== T_NUMBER || tok_value !== 32'd7 || tok_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid %b type %0d value %h last %b, required 1 9 00000007 0",
                         i, tok_valid, tok_type, tok_value, tok_last);
            end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b, required 0", i, in_ready); end
        end
        @(posedge clk);
        #1;
        tok_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle(3);
        exp.push_back(mk(T_NUMBER, 32'd7, 0));
        exp.push_back(mk(T_COMMA, 0, 1));
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL bp_count: got %0d tokens, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++;
                $display("FAIL bp_tok%0d: missing, required type %0d value %h last %b", i, exp[i].typ, exp[i].val, exp[i].last);
            end else if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL bp_tok%0d: type %0d value %h last %b, required type %0d value %h last %b",
                         i, got[i].typ, got[i].val, got[i].last, exp[i].typ, exp[i].val, exp[i].last);
            end
        end
    endtask

    task automatic test_errors;
        do_reset(1);
        got.delete();
        send_str("tru", 1'b1);
        idle(3);
        checks++;
        if (got.size() != 1) begin
            errors++;
            $display("FAIL err_tru_count: got %0d tokens, required 1", got.size());
        end else if (got[0] !== mk(T_ERROR, 0, 1)) begin
            errors++;
            $display("FAIL err_tru_tok: type %0d value %h last %b, required type 15 value 0 last 1", got[0].typ, got[0].val, got[0].last);
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_tru_flag: got %b, required 1", err); end
        do_reset(1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b, required 0", err); end
        got.delete();
        send_str("\"\\u0041\"", 1'b1);
        idle(3);
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL err_u_count: got %0d tokens, required 2", got.size());
        end else begin
            if (got[0] !== mk(T_STR_BEGIN, 0, 0)) begin
                errors++;
                $display("FAIL err_u_tok0: type %0d value %h last %b, required type 10 value 0 last 0", got[0].typ, got[0].val, got[0].last);
            end
            if (got[1] !== mk(T_ERROR, 0, 1)) begin
                errors++;
                $display("FAIL err_u_tok1: type %0d value %h last %b, required type 15 value 0 last 1", got[1].typ, got[1].val, got[1].last);
            end
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_u_flag: got %b, required 1", err); end
    endtask

    task automatic test_reset_mid_string;
        do_reset(1);
        send_str("\"ab", 1'b0);
        idle(2);
        do_reset(1);
        got.delete();
        exp.delete();
        stalls = 0;
        send_str("[]", 1'b1);
        idle(3);
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL rst_first_byte_stalls: got %0d, required 0", stalls); end
        exp.push_back(mk(T_LBRACK, 0, 0));
        exp.push_back(mk(T_RBRACK, 0, 1));
        checks++;
        if (got.size() != exp.size()) begin errors++; $display("FAIL rstmid_count: got %0d tokens, required %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++;
                $display("FAIL rstmid_tok%0d: missing, required type %0d value %h last %b", i, exp[i].typ, exp[i].val, exp[i].last);
            end else if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL rstmid_tok%0d: type %0d value %h last %b, required type %0d value %h last %b",
                         i, got[i].typ, got[i].val, got[i].last, exp[i].typ, exp[i].val, exp[i].last);
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b, required 0", err); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_object();
        test_strings_literals();
        test_number_bounds();
        test_backpressure();
        test_errors();
        test_reset_mid_string();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
